instrumented_adder_wb_regs: RTL and testbench

INSTRUMENTED_ADDER_WB_REGS -- requirements
Module: instrumented_adder_wb_regs

---
 rtl/instrumented_adder_wb_regs.sv | 163 ++++++++++++++++
 tb/tb_instrumented_adder_wb_regs.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_wb_regs.sv
// Wishbone register bank that configures the instrumented ring-oscillator adder,
// synchronizes its done flag and snapshots the oscillator counter on completion.
module instrumented_adder_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hADD0_0001
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        done,
    input  logic [3:0]  sum_out,
    input  logic [31:0] ring_osc_counter_out,
    output logic        stop_b,
    output logic        extra_inverter,
    output logic        bypass_b,
    output logic        control_b,
    output logic        force_count,
    output logic        counter_enable,
    output logic        counter_load,
    output logic [3:0]  a_input_ext_bit_b,
    output logic [3:0]  a_input_ring_bit_b,
    output logic [3:0]  s_output_bit_b,
    output logic [3:0]  a_input,
    output logic [3:0]  b_input,
    output logic [31:0] integration_time,
    output logic        irq
);

    localparam logic [2:0]  IDX_CTRL   = 3'd0;
    localparam logic [2:0]  IDX_INTEG  = 3'd1;
    localparam logic [2:0]  IDX_CMD    = 3'd2;
    localparam logic [2:0]  IDX_STATUS = 3'd3;
    localparam logic [2:0]  IDX_COUNT  = 3'd4;
    localparam logic [2:0]  IDX_ID     = 3'd5;
    localparam logic [31:0] CTRL_MASK  = 32'h07FF_FFFF;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic        ack_r;
    logic [31:0] dat_r;
    logic        load_r;
    logic [31:0] ctrl_r;
    logic [31:0] integ_r;
    logic [31:0] count_r;
    logic        sticky_r;
    logic        sync1_r;
    logic        sync2_r;
    logic        sync3_r;

    logic        req_s;
    logic        take_s;
    logic        wr_s;
    logic        w1c_s;
    logic        rise_s;
    logic [2:0]  idx_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign req_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign idx_s    = wbs_adr_i[4:2];
    // A request is taken only while ack is low, so acks never run back to back.
    assign take_s   = req_s & ~ack_r;
    assign wr_s     = take_s & wbs_we_i;
    assign w1c_s    = wr_s & (idx_s == IDX_STATUS) & wbs_dat_i[1];
    assign rise_s   = sync2_r & ~sync3_r;
    assign unused_s = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    // Read-data multiplexer over the register map.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (idx_s)
            IDX_CTRL:   rdata_s = ctrl_r;
            IDX_INTEG:  rdata_s = integ_r;
            IDX_STATUS: rdata_s = {24'h00_0000, sum_out, 2'b00, sticky_r, sync2_r};
            IDX_COUNT:  rdata_s = count_r;
            IDX_ID:     rdata_s = ID_VALUE;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake, read-data capture and writable configuration registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ack_r   <= 1'b0;
            dat_r   <= 32'h0000_0000;
            load_r  <= 1'b0;
            ctrl_r  <= 32'h0000_0000;
            integ_r <= 32'h0000_0000;
        end else begin
            ack_r  <= take_s;
            load_r <= wr_s & (idx_s == IDX_CMD) & wbs_dat_i[0];
            if (take_s) begin
                dat_r <= rdata_s;
            end else begin
                dat_r <= 32'h0000_0000;
            end
            if (wr_s && (idx_s == IDX_CTRL)) begin
                ctrl_r <= byte_merge(ctrl_r, wbs_dat_i, wbs_sel_i) & CTRL_MASK;
            end
            if (wr_s && (idx_s == IDX_INTEG)) begin
                integ_r <= byte_merge(integ_r, wbs_dat_i, wbs_sel_i);
            end
        end
    end

    // Done synchronizer, edge detect, counter snapshot and sticky completion flag.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync3_r  <= 1'b0;
            count_r  <= 32'h0000_0000;
            sticky_r <= 1'b0;
        end else begin
            sync1_r  <= done;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            // A fresh completion outranks a simultaneous software clear.
            sticky_r <= rise_s | (sticky_r & ~w1c_s);
            if (rise_s) begin
                count_r <= ring_osc_counter_out;
            end
        end
    end

    assign wbs_ack_o          = ack_r;
    assign wbs_dat_o          = dat_r;
    assign counter_load       = load_r;
    assign integration_time   = integ_r;
    assign stop_b             = ctrl_r[0];
    assign extra_inverter     = ctrl_r[1];
    assign bypass_b           = ctrl_r[2];
    assign control_b          = ctrl_r[3];
    assign force_count        = ctrl_r[4];
    assign a_input_ext_bit_b  = ctrl_r[8:5];
    assign a_input_ring_bit_b = ctrl_r[12:9];
    assign s_output_bit_b     = ctrl_r[16:13];
    assign a_input            = ctrl_r[20:17];
    assign b_input            = ctrl_r[24:21];
    assign counter_enable     = ctrl_r[25];
    assign irq                = sticky_r & ctrl_r[26];

endmodule

// File: tb/tb_instrumented_adder_wb_regs.sv
// Directed bench for instrumented_adder_wb_regs with a register-level reference model.
module tb_instrumented_adder_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        done;
    logic [3:0]  sum_out;
    logic [31:0] ring_osc_counter_out;
    logic        stop_b, extra_inverter, bypass_b, control_b, force_count;
    logic        counter_enable, counter_load;
    logic [3:0]  a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b, a_input, b_input;
    logic [31:0] integration_time;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_ctrl, m_integ, m_count;
    logic        m_sticky, m_done_sync, exp_load;
    bit          irq_chk;
    logic [31:0] rd;

    always #5 clk = ~clk;

    instrumented_adder_wb_regs dut (
        .clk(clk), .reset_b(reset_b),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .done(done), .sum_out(sum_out), .ring_osc_counter_out(ring_osc_counter_out),
        .stop_b(stop_b), .extra_inverter(extra_inverter), .bypass_b(bypass_b),
        .control_b(control_b), .force_count(force_count),
        .counter_enable(counter_enable), .counter_load(counter_load),
        .a_input_ext_bit_b(a_input_ext_bit_b), .a_input_ring_bit_b(a_input_ring_bit_b),
        .s_output_bit_b(s_output_bit_b), .a_input(a_input), .b_input(b_input),
        .integration_time(integration_time), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_ctrl;
            3'd1:    return m_integ;
            3'd3:    return {24'h0, sum_out, 2'b00, m_sticky, m_done_sync};
            3'd4:    return m_count;
            3'd5:    return 32'hADD0_0001;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = 32'h0; m_integ = 32'h0; m_count = 32'h0;
        m_sticky = 1'b0; m_done_sync = 1'b0; exp_load = 1'b0;
    endtask

    task automatic bus_idle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    endtask

    // One classic cycle; strobe held through the ack cycle to prove single-cycle ack.
    task automatic wb_cycle(input logic [2:0] idx, input logic we, input logic [31:0] wdata,
                            input logic [3:0] sel, output logic [31:0] rdata);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = BASE | {27'h0, idx, 2'b00}; wbs_dat_i = wdata; wbs_sel_i = sel;
        @(posedge clk); #1;
        chk("ack_latency", {31'h0, wbs_ack_o}, 32'h1);
        rdata = wbs_dat_o;
        if (we) begin
            case (idx)
                3'd0: m_ctrl  = merge(m_ctrl, wdata, sel) & 32'h07FF_FFFF;
                3'd1: m_integ = merge(m_integ, wdata, sel);
                3'd2: exp_load = wdata[0];
                3'd3: if (wdata[1]) m_sticky = 1'b0;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        exp_load = 1'b0;
        chk("ack_single", {31'h0, wbs_ack_o}, 32'h0);
        chk("dat_idle", wbs_dat_o, 32'h0);
        bus_idle();
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_cycle(idx, 1'b1, d, sel, dummy);
    endtask

    task automatic wb_read_model(input string name, input logic [2:0] idx);
        logic [31:0] r;
        logic [31:0] e;
        e = m_read(idx);
        wb_cycle(idx, 1'b0, 32'h0, 4'hF, r);
        chk(name, r, e);
    endtask

    // Continuous comparison of adder-facing outputs against the model.
    always @(negedge clk) begin
        chk("ctrl_outputs",
            {6'h0, counter_enable, b_input, a_input, s_output_bit_b, a_input_ring_bit_b,
             a_input_ext_bit_b, force_count, control_b, bypass_b, extra_inverter, stop_b},
            m_ctrl & 32'h03FF_FFFF);
        chk("integration_time", integration_time, m_integ);
        chk("counter_load", {31'h0, counter_load}, {31'h0, exp_load});
        if (irq_chk) chk("irq", {31'h0, irq}, {31'h0, m_sticky & m_ctrl[26]});
    end

    initial begin
        reset_b = 1'b0; bus_idle();
        done = 1'b0; sum_out = 4'hA; ring_osc_counter_out = 32'h0;
        m_reset(); irq_chk = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_stop_b", {31'h0, stop_b}, 32'h0);
        @(posedge clk); #1 reset_b = 1'b1;

        // CTRL write/read-back
        wb_write(3'd0, 32'h0600_0001, 4'hF);
        wb_cycle(3'd0, 1'b0, 32'h0, 4'hF, rd);
        chk("ctrl_readback", rd, 32'h0600_0001);
        chk("stop_b", {31'h0, stop_b}, 32'h1);
        chk("counter_enable", {31'h0, counter_enable}, 32'h1);

        // INTEG byte lanes
        wb_write(3'd1, 32'h1234_5678, 4'b0010);
        wb_cycle(3'd1, 1'b0, 32'h0, 4'hF, rd);
        chk("integ_sel", rd, 32'h0000_5600);
        chk("integ_out", integration_time, 32'h0000_5600);
        wb_write(3'd1, 32'hA5A5_A5A5, 4'b1001);
        wb_read_model("integ_sel2", 3'd1);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'b0100);
        wb_read_model("ctrl_sel", 3'd0);
        chk("ctrl_sel_lit", m_ctrl, 32'h06FF_0001);

        // CMD pulse and read-as-zero
        wb_write(3'd2, 32'h0000_0001, 4'hF);
        chk("load_after", {31'h0, counter_load}, 32'h0);
        wb_write(3'd2, 32'h0000_0000, 4'hF);
        wb_read_model("cmd_read", 3'd2);

        // Done capture, sticky and irq
        ring_osc_counter_out = 32'd1000; irq_chk = 1'b0;
        @(posedge clk); #1 done = 1'b1;
        repeat (3) @(posedge clk);
        #1 m_count = 32'd1000; m_sticky = 1'b1; m_done_sync = 1'b1; irq_chk = 1'b1;
        chk("irq_set", {31'h0, irq}, 32'h1);
        ring_osc_counter_out = 32'd2000;
        wb_cycle(3'd4, 1'b0, 32'h0, 4'hF, rd);
        chk("count_1000", rd, 32'd1000);
        wb_cycle(3'd3, 1'b0, 32'h0, 4'hF, rd);
        chk("status_set", rd, 32'h0000_00A3);
        wb_write(3'd3, 32'h0000_0002, 4'hF);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        wb_read_model("status_clr", 3'd3);
        done = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_done_sync = 1'b0;

        // Done edge coincident with the W1C edge
        irq_chk = 1'b0;
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk);
        wb_write(3'd3, 32'h0000_0002, 4'hF);
        m_sticky = 1'b1; m_done_sync = 1'b1; m_count = 32'd2000; irq_chk = 1'b1;
        wb_cycle(3'd3, 1'b0, 32'h0, 4'hF, rd);
        chk("set_wins", rd, 32'h0000_00A3);
        wb_read_model("count_2000", 3'd4);
        done = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_done_sync = 1'b0;

        // Unmapped indices and ID
        wb_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        wb_read_model("idx6", 3'd6);
        wb_read_model("idx7", 3'd7);
        wb_cycle(3'd5, 1'b0, 32'h0, 4'hF, rd);
        chk("id", rd, 32'hADD0_0001);

        // Off-base request never acks nor writes
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0100; wbs_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 chk("offbase_noack", {31'h0, wbs_ack_o}, 32'h0);
        end
        bus_idle();

        // Strobe dropped before any sampling edge
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE; wbs_dat_i = 32'h0;
        #3 bus_idle();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 chk("drop_noack", {31'h0, wbs_ack_o}, 32'h0);
        end

        // Reset mid-transaction aborts the pending ack
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE | 32'h0000_0004;
        @(posedge clk); #1 reset_b = 1'b0; m_reset();
        #1 chk("rst_mid_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_mid_dat", wbs_dat_o, 32'h0);
        @(posedge clk); #1 bus_idle();
        @(posedge clk); #1 reset_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 chk("rst_noack", {31'h0, wbs_ack_o}, 32'h0);
        end
        wb_read_model("status_after_rst", 3'd3);
        wb_read_model("integ_after_rst", 3'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
